// File: rtl/axil_pkg.sv
// ---------------------------------------------------------------------------
// axil_pkg
// Shared definitions for the AXI4-Lite register file slice.
//   RESP_*  : AXI response encodings driven on BRESP / RRESP
//   clog2   : constant-foldable ceiling log2, used to size the register
//             index and the byte-offset field of the address
// ---------------------------------------------------------------------------
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Smallest r such that 2**r >= value; value is at least 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/axil_hold_slot.sv
// ---------------------------------------------------------------------------
// axil_hold_slot
// One-entry valid/ready holding register. A beat is captured when
// i_in_valid meets o_in_ready; the slot then reports full and refuses more
// beats until the consumer pops it. Ready is its own flop so the AXI READY
// outputs never depend combinationally on any input.
// Ports:
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_in_valid/o_in_ready producer handshake
//   i_data/o_data         beat captured / beat held
//   o_full                slot holds a beat
//   i_pop                 consumer takes the held beat (only while full)
// ---------------------------------------------------------------------------
module axil_hold_slot #(
  parameter int W = 32
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_in_valid,
  output logic         o_in_ready,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_data,
  output logic         o_full,
  input  logic         i_pop
);

  logic         r_full;
  logic         r_ready;
  logic [W-1:0] r_data;

  // Capture and release of the single beat. Ready is always the inverse of
  // full, so a capture and a pop can never fall on the same edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_full  <= 1'b0;
      r_ready <= 1'b1;
      r_data  <= '0;
    end else if (i_in_valid && r_ready) begin
      r_full  <= 1'b1;
      r_ready <= 1'b0;
      r_data  <= i_data;
    end else if (i_pop) begin
      r_full  <= 1'b0;
      r_ready <= 1'b1;
    end
  end

  assign o_in_ready = r_ready;
  assign o_data     = r_data;
  assign o_full     = r_full;

endmodule

// File: rtl/s_axil_register_file.sv
// ---------------------------------------------------------------------------
// s_axil_register_file
// AXI4-Lite slave with NUM_REG software-visible registers, also exported
// flat on REG_OUT for fabric logic. AW, W and AR beats are parked in
// one-entry slots; a write commits once AW and W are both held and the B
// channel is free, a read commits once AR is held and the R channel is free.
// Ports:
//   ACLK, ARESET              clock, asynchronous active-high reset
//   AW*/W*/B*                 write address, data and response channels
//   AR*/R*                    read address and data channels
//   REG_OUT                   register k at [k*DW +: DW]
// ---------------------------------------------------------------------------
module s_axil_register_file
  import axil_pkg::*;
#(
  parameter int S_AXI_DATA_WIDTH = 32,
  parameter int S_AXI_ADDR_WIDTH = 32,
  parameter int NUM_REG          = 16
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [S_AXI_ADDR_WIDTH-1:0]     AWADDR,
  input  logic                            AWVALID,
  output logic                            AWREADY,
  input  logic [S_AXI_DATA_WIDTH-1:0]     WDATA,
  input  logic [S_AXI_DATA_WIDTH/8-1:0]   WSTRB,
  input  logic                            WVALID,
  output logic                            WREADY,
  output logic [1:0]                      BRESP,
  output logic                            BVALID,
  input  logic                            BREADY,
  input  logic [S_AXI_ADDR_WIDTH-1:0]     ARADDR,
  input  logic                            ARVALID,
  output logic                            ARREADY,
  output logic [S_AXI_DATA_WIDTH-1:0]     RDATA,
  output logic [1:0]                      RRESP,
  output logic                            RVALID,
  input  logic                            RREADY,
  output logic [NUM_REG*S_AXI_DATA_WIDTH-1:0] REG_OUT
);

  localparam int DW   = S_AXI_DATA_WIDTH;
  localparam int AW   = S_AXI_ADDR_WIDTH;
  localparam int NB   = DW / 8;
  localparam int IDXW = clog2(NUM_REG);
  localparam int BOFF = clog2(NB);
  localparam logic [AW-1:0] ADDR_LIMIT = AW'(NUM_REG * NB);

  logic [DW-1:0]    r_regs [NUM_REG];
  logic             r_bValid;
  logic [1:0]       r_bResp;
  logic             r_rValid;
  logic [1:0]       r_rResp;
  logic [DW-1:0]    r_rData;

  logic             w_awFull;
  logic             w_wFull;
  logic             w_arFull;
  logic [AW-1:0]    w_awAddr;
  logic [AW-1:0]    w_arAddr;
  logic [DW+NB-1:0] w_wBeat;
  logic [DW-1:0]    w_wData;
  logic [NB-1:0]    w_wStrb;
  logic             w_wrCommit;
  logic             w_rdCommit;
  logic             w_awOor;
  logic             w_arOor;
  logic [IDXW-1:0]  w_awIdx;
  logic [IDXW-1:0]  w_arIdx;

  axil_hold_slot #(.W(AW)) u_awSlot (
    .i_clk      (ACLK),
    .i_rst      (ARESET),
    .i_in_valid (AWVALID),
    .o_in_ready (AWREADY),
    .i_data     (AWADDR),
    .o_data     (w_awAddr),
    .o_full     (w_awFull),
    .i_pop      (w_wrCommit)
  );

  axil_hold_slot #(.W(DW + NB)) u_wSlot (
    .i_clk      (ACLK),
    .i_rst      (ARESET),
    .i_in_valid (WVALID),
    .o_in_ready (WREADY),
    .i_data     ({WSTRB, WDATA}),
    .o_data     (w_wBeat),
    .o_full     (w_wFull),
    .i_pop      (w_wrCommit)
  );

  axil_hold_slot #(.W(AW)) u_arSlot (
    .i_clk      (ACLK),
    .i_rst      (ARESET),
    .i_in_valid (ARVALID),
    .o_in_ready (ARREADY),
    .i_data     (ARADDR),
    .o_data     (w_arAddr),
    .o_full     (w_arFull),
    .i_pop      (w_rdCommit)
  );

  assign w_wData    = w_wBeat[DW-1:0];
  assign w_wStrb    = w_wBeat[DW +: NB];
  assign w_awOor    = (w_awAddr >= ADDR_LIMIT);
  assign w_arOor    = (w_arAddr >= ADDR_LIMIT);
  assign w_awIdx    = w_awAddr[BOFF +: IDXW];
  assign w_arIdx    = w_arAddr[BOFF +: IDXW];

  // A new response may be loaded while the previous one is being accepted
  // on the same edge, which keeps VALID high without a bubble.
  assign w_wrCommit = w_awFull && w_wFull && (!r_bValid || BREADY);
  assign w_rdCommit = w_arFull && (!r_rValid || RREADY);

  // Register array: byte-lane update on an in-range write commit only.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      for (int k = 0; k < NUM_REG; k++) r_regs[k] <= '0;
    end else if (w_wrCommit && !w_awOor) begin
      for (int b = 0; b < NB; b++) begin
        if (w_wStrb[b]) r_regs[w_awIdx][8*b +: 8] <= w_wData[8*b +: 8];
      end
    end
  end

  // Write response: loaded on commit, held until BREADY accepts it.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_bValid <= 1'b0;
      r_bResp  <= RESP_OKAY;
    end else if (w_wrCommit) begin
      r_bValid <= 1'b1;
      r_bResp  <= w_awOor ? RESP_SLVERR : RESP_OKAY;
    end else if (BREADY) begin
      r_bValid <= 1'b0;
    end
  end

  // Read response: samples the array before any same-edge write lands.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_rValid <= 1'b0;
      r_rResp  <= RESP_OKAY;
      r_rData  <= '0;
    end else if (w_rdCommit) begin
      r_rValid <= 1'b1;
      r_rResp  <= w_arOor ? RESP_SLVERR : RESP_OKAY;
      r_rData  <= w_arOor ? '0 : r_regs[w_arIdx];
    end else if (RREADY) begin
      r_rValid <= 1'b0;
    end
  end

  assign BVALID = r_bValid;
  assign BRESP  = r_bResp;
  assign RVALID = r_rValid;
  assign RRESP  = r_rResp;
  assign RDATA  = r_rData;

  for (genvar k = 0; k < NUM_REG; k++) begin : g_regOut
    assign REG_OUT[k*DW +: DW] = r_regs[k];
  end

endmodule

// File: tb/tb_s_axil_register_file.sv
// ---------------------------------------------------------------------------
// tb_s_axil_register_file
// Self-checking bench for s_axil_register_file (32-bit data, 16 registers).
// A plain array of register values stands in for the slave; each scenario
// task drives the AXI channels and compares against that array.
// ---------------------------------------------------------------------------
module tb_s_axil_register_file;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic          ACLK;
  logic          ARESET;
  logic [31:0]   AWADDR;
  logic          AWVALID;
  logic          AWREADY;
  logic [31:0]   WDATA;
  logic [3:0]    WSTRB;
  logic          WVALID;
  logic          WREADY;
  logic [1:0]    BRESP;
  logic          BVALID;
  logic          BREADY;
  logic [31:0]   ARADDR;
  logic          ARVALID;
  logic          ARREADY;
  logic [31:0]   RDATA;
  logic [1:0]    RRESP;
  logic          RVALID;
  logic          RREADY;
  logic [511:0]  REG_OUT;

  logic [31:0] model [16];
  int nVectors;
  int nMiss;

  s_axil_register_file #(
    .S_AXI_DATA_WIDTH (32),
    .S_AXI_ADDR_WIDTH (32),
    .NUM_REG          (16)
  ) dut (
    .ACLK    (ACLK),
    .ARESET  (ARESET),
    .AWADDR  (AWADDR),
    .AWVALID (AWVALID),
    .AWREADY (AWREADY),
    .WDATA   (WDATA),
    .WSTRB   (WSTRB),
    .WVALID  (WVALID),
    .WREADY  (WREADY),
    .BRESP   (BRESP),
    .BVALID  (BVALID),
    .BREADY  (BREADY),
    .ARADDR  (ARADDR),
    .ARVALID (ARVALID),
    .ARREADY (ARREADY),
    .RDATA   (RDATA),
    .RRESP   (RRESP),
    .RVALID  (RVALID),
    .RREADY  (RREADY),
    .REG_OUT (REG_OUT)
  );

  // 10 ns clock; stimulus changes and sampling happen 1 ns after the edge.
  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  // Reference update: a write lands only below 64 bytes, lane by lane.
  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] cur;
    if (a < 32'd64) begin
      cur = model[a >> 2];
      for (int b = 0; b < 4; b++) if (s[b]) cur[8*b +: 8] = d[8*b +: 8];
      model[a >> 2] = cur;
    end
  endtask

  // Full write transaction with independent AW/W start delays; BREADY early.
  task automatic write_txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int awDelay, input int wDelay,
                           output logic [1:0] resp, output bit ok);
    int cyc;
    bit awDone, wDone, awHs, wHs;
    cyc = 0; awDone = 0; wDone = 0; ok = 1;
    AWADDR = a; WDATA = d; WSTRB = s; BREADY = 1'b1;
    AWVALID = (awDelay == 0);
    WVALID  = (wDelay == 0);
    while (!(awDone && wDone) && cyc < 50) begin
      awHs = AWVALID && AWREADY;
      wHs  = WVALID && WREADY;
      step(); cyc++;
      if (awHs) begin awDone = 1; AWVALID = 1'b0; end
      if (wHs)  begin wDone  = 1; WVALID  = 1'b0; end
      if (!awDone && cyc >= awDelay) AWVALID = 1'b1;
      if (!wDone && cyc >= wDelay)   WVALID  = 1'b1;
    end
    AWVALID = 1'b0; WVALID = 1'b0;
    if (!(awDone && wDone)) ok = 0;
    cyc = 0;
    while (!BVALID && cyc < 50) begin step(); cyc++; end
    if (!BVALID) ok = 0;
    resp = BRESP;
    step();
    BREADY = 1'b0;
  endtask

  task automatic read_txn(input logic [31:0] a, output logic [31:0] d,
                          output logic [1:0] resp, output bit ok);
    int cyc;
    bit arDone;
    cyc = 0; arDone = 0; ok = 1;
    ARADDR = a; ARVALID = 1'b1; RREADY = 1'b1;
    while (!arDone && cyc < 50) begin
      if (ARREADY) arDone = 1;
      step(); cyc++;
    end
    ARVALID = 1'b0;
    if (!arDone) ok = 0;
    cyc = 0;
    while (!RVALID && cyc < 50) begin step(); cyc++; end
    if (!RVALID) ok = 0;
    d = RDATA; resp = RRESP;
    step();
    RREADY = 1'b0;
  endtask

  // Outputs while ARESET is held must be at their idle values.
  task automatic test_reset();
    #2;
    nVectors++;
    if ({AWREADY, WREADY, ARREADY} !== 3'b111) begin
      nMiss++; $display("[TB] FAIL reset_ready got=%b want=111", {AWREADY, WREADY, ARREADY});
    end
    nVectors++;
    if ({BVALID, RVALID, BRESP, RRESP} !== 6'b0) begin
      nMiss++; $display("[TB] FAIL reset_resp got=%b want=000000", {BVALID, RVALID, BRESP, RRESP});
    end
    nVectors++;
    if (RDATA !== 32'h0) begin
      nMiss++; $display("[TB] FAIL reset_rdata got=%h want=0", RDATA);
    end
    nVectors++;
    if (REG_OUT !== 512'h0) begin
      nMiss++; $display("[TB] FAIL reset_regout got=%h want=0", REG_OUT);
    end
    step(); step();
    ARESET = 1'b0;
    step();
  endtask

  // Write k+1 into every register with W one cycle after AW, then read back.
  task automatic test_fill();
    logic [1:0]  resp;
    logic [31:0] d;
    bit ok;
    for (int k = 0; k < 16; k++) begin
      write_txn(32'(4 * k), 32'(k + 1), 4'hF, 0, 1, resp, ok);
      model_write(32'(4 * k), 32'(k + 1), 4'hF);
      nVectors++;
      if (!ok || resp !== OKAY) begin
        nMiss++; $display("[TB] FAIL fill_bresp k=%0d got=%b ok=%0d want=00", k, resp, ok);
      end
    end
    for (int k = 0; k < 16; k++) begin
      read_txn(32'(4 * k), d, resp, ok);
      nVectors++;
      if (!ok || d !== 32'(k + 1) || resp !== OKAY) begin
        nMiss++; $display("[TB] FAIL fill_read k=%0d got=%h/%b want=%h/00", k, d, resp, k + 1);
      end
    end
    for (int k = 0; k < 16; k++) begin
      nVectors++;
      if (REG_OUT[k*32 +: 32] !== model[k]) begin
        nMiss++; $display("[TB] FAIL fill_regout k=%0d got=%h want=%h", k, REG_OUT[k*32 +: 32], model[k]);
      end
    end
  endtask

  // W three cycles ahead of AW, then AW and W together; check B timing.
  task automatic test_order();
    logic [31:0] d1, d2;
    d1 = $urandom; d2 = $urandom;
    BREADY = 1'b1;
    WDATA = d1; WSTRB = 4'hF; WVALID = 1'b1;
    step(); WVALID = 1'b0;
    nVectors++;
    if (WREADY !== 1'b0 || BVALID !== 1'b0) begin
      nMiss++; $display("[TB] FAIL order_wheld got=%b%b want=00", WREADY, BVALID);
    end
    step(); step();
    AWADDR = 32'h14; AWVALID = 1'b1;
    step(); AWVALID = 1'b0;
    nVectors++;
    if (BVALID !== 1'b0) begin
      nMiss++; $display("[TB] FAIL order_wfirst_early got=%b want=0", BVALID);
    end
    step();
    nVectors++;
    if (BVALID !== 1'b1 || BRESP !== OKAY) begin
      nMiss++; $display("[TB] FAIL order_wfirst_b got=%b/%b want=1/00", BVALID, BRESP);
    end
    model_write(32'h14, d1, 4'hF);
    step();
    nVectors++;
    if (BVALID !== 1'b0 || REG_OUT[5*32 +: 32] !== model[5]) begin
      nMiss++; $display("[TB] FAIL order_wfirst_once got=%b/%h want=0/%h", BVALID, REG_OUT[5*32 +: 32], model[5]);
    end
    AWADDR = 32'h18; AWVALID = 1'b1; WDATA = d2; WSTRB = 4'hF; WVALID = 1'b1;
    step(); AWVALID = 1'b0; WVALID = 1'b0;
    nVectors++;
    if (BVALID !== 1'b0) begin
      nMiss++; $display("[TB] FAIL order_same_early got=%b want=0", BVALID);
    end
    step();
    nVectors++;
    if (BVALID !== 1'b1 || BRESP !== OKAY) begin
      nMiss++; $display("[TB] FAIL order_same_b got=%b/%b want=1/00", BVALID, BRESP);
    end
    model_write(32'h18, d2, 4'hF);
    step();
    nVectors++;
    if (BVALID !== 1'b0 || REG_OUT[6*32 +: 32] !== model[6]) begin
      nMiss++; $display("[TB] FAIL order_same_once got=%b/%h want=0/%h", BVALID, REG_OUT[6*32 +: 32], model[6]);
    end
    BREADY = 1'b0;
  endtask

  // Partial strobe merges into an existing word.
  task automatic test_strobe();
    logic [1:0]  resp;
    logic [31:0] d;
    bit ok;
    write_txn(32'h08, 32'hAABBCCDD, 4'hF, 0, 0, resp, ok);
    model_write(32'h08, 32'hAABBCCDD, 4'hF);
    write_txn(32'h08, 32'h11223344, 4'b0101, 1, 0, resp, ok);
    model_write(32'h08, 32'h11223344, 4'b0101);
    read_txn(32'h08, d, resp, ok);
    nVectors++;
    if (!ok || d !== 32'hAA22CC44 || resp !== OKAY) begin
      nMiss++; $display("[TB] FAIL strobe_merge got=%h/%b want=aa22cc44/00", d, resp);
    end
  endtask

  // First address past the array answers SLVERR and touches nothing.
  task automatic test_out_of_range();
    logic [1:0]  resp;
    logic [31:0] d;
    bit ok;
    write_txn(32'h40, $urandom, 4'hF, 0, 0, resp, ok);
    nVectors++;
    if (!ok || resp !== SLVERR) begin
      nMiss++; $display("[TB] FAIL oor_bresp got=%b want=10", resp);
    end
    for (int k = 0; k < 16; k++) begin
      nVectors++;
      if (REG_OUT[k*32 +: 32] !== model[k]) begin
        nMiss++; $display("[TB] FAIL oor_regout k=%0d got=%h want=%h", k, REG_OUT[k*32 +: 32], model[k]);
      end
    end
    read_txn(32'h40, d, resp, ok);
    nVectors++;
    if (!ok || d !== 32'h0 || resp !== SLVERR) begin
      nMiss++; $display("[TB] FAIL oor_read got=%h/%b want=0/10", d, resp);
    end
  endtask

  // Random mix of reads and writes, some past the array, random delays.
  task automatic test_random();
    logic [1:0]  resp;
    logic [31:0] a, d, expD;
    logic [3:0]  s;
    bit ok;
    for (int i = 0; i < 40; i++) begin
      a = 32'($urandom_range(0, 19) * 4 + $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom; s = 4'($urandom_range(0, 15));
        write_txn(a, d, s, $urandom_range(0, 2), $urandom_range(0, 2), resp, ok);
        model_write(a, d, s);
        nVectors++;
        if (!ok || resp !== ((a < 32'd64) ? OKAY : SLVERR)) begin
          nMiss++; $display("[TB] FAIL rand_write a=%h got=%b ok=%0d", a, resp, ok);
        end
      end else begin
        expD = (a < 32'd64) ? model[a >> 2] : 32'h0;
        read_txn(a, d, resp, ok);
        nVectors++;
        if (!ok || d !== expD || resp !== ((a < 32'd64) ? OKAY : SLVERR)) begin
          nMiss++; $display("[TB] FAIL rand_read a=%h got=%h/%b want=%h", a, d, resp, expD);
        end
      end
    end
    for (int k = 0; k < 16; k++) begin
      nVectors++;
      if (REG_OUT[k*32 +: 32] !== model[k]) begin
        nMiss++; $display("[TB] FAIL rand_regout k=%0d got=%h want=%h", k, REG_OUT[k*32 +: 32], model[k]);
      end
    end
  endtask

  // Stall both response channels with second AW/W/AR already queued.
  task automatic test_back_to_back();
    logic [31:0] d1, expR1;
    d1 = $urandom;
    expR1 = model[4];
    BREADY = 1'b0; RREADY = 1'b0;
    AWADDR = 32'h0C; WDATA = d1; WSTRB = 4'hF; ARADDR = 32'h10;
    AWVALID = 1'b1; WVALID = 1'b1; ARVALID = 1'b1;
    step();
    model_write(32'h0C, d1, 4'hF);
    AWADDR = 32'h44; WDATA = $urandom; ARADDR = 32'h0C;
    step();
    step();
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    for (int i = 0; i < 5; i++) begin
      nVectors++;
      if (BVALID !== 1'b1 || BRESP !== OKAY || RVALID !== 1'b1 || RDATA !== expR1 || RRESP !== OKAY) begin
        nMiss++; $display("[TB] FAIL b2b_hold i=%0d got=%b%b/%b/%h want=11/00/%h", i, BVALID, RVALID, BRESP, RDATA, expR1);
      end
      nVectors++;
      if ({AWREADY, WREADY, ARREADY} !== 3'b000) begin
        nMiss++; $display("[TB] FAIL b2b_slots i=%0d got=%b want=000", i, {AWREADY, WREADY, ARREADY});
      end
      step();
    end
    BREADY = 1'b1; RREADY = 1'b1;
    step();
    nVectors++;
    if (BVALID !== 1'b1 || BRESP !== SLVERR) begin
      nMiss++; $display("[TB] FAIL b2b_second_b got=%b/%b want=1/10", BVALID, BRESP);
    end
    nVectors++;
    if (RVALID !== 1'b1 || RDATA !== d1 || RRESP !== OKAY) begin
      nMiss++; $display("[TB] FAIL b2b_second_r got=%b/%h/%b want=1/%h/00", RVALID, RDATA, RRESP, d1);
    end
    step();
    nVectors++;
    if (BVALID !== 1'b0 || RVALID !== 1'b0) begin
      nMiss++; $display("[TB] FAIL b2b_drain got=%b%b want=00", BVALID, RVALID);
    end
    for (int k = 0; k < 16; k++) begin
      nVectors++;
      if (REG_OUT[k*32 +: 32] !== model[k]) begin
        nMiss++; $display("[TB] FAIL b2b_regout k=%0d got=%h want=%h", k, REG_OUT[k*32 +: 32], model[k]);
      end
    end
    BREADY = 1'b0; RREADY = 1'b0;
  endtask

  // Reset between AW and W: everything clears at once, no orphan response.
  task automatic test_reset_mid();
    AWADDR = 32'h04; AWVALID = 1'b1;
    step(); AWVALID = 1'b0;
    ARESET = 1'b1;
    #1;
    for (int k = 0; k < 16; k++) model[k] = 32'h0;
    nVectors++;
    if ({AWREADY, WREADY, ARREADY, BVALID, RVALID} !== 5'b11100) begin
      nMiss++; $display("[TB] FAIL rstmid_flags got=%b want=11100", {AWREADY, WREADY, ARREADY, BVALID, RVALID});
    end
    nVectors++;
    if (REG_OUT !== 512'h0 || RDATA !== 32'h0) begin
      nMiss++; $display("[TB] FAIL rstmid_regs got=%h/%h want=0", REG_OUT[63:0], RDATA);
    end
    step();
    ARESET = 1'b0;
    WDATA = $urandom; WSTRB = 4'hF; WVALID = 1'b1; BREADY = 1'b1;
    step(); WVALID = 1'b0;
    for (int i = 0; i < 5; i++) begin
      nVectors++;
      if (BVALID !== 1'b0) begin
        nMiss++; $display("[TB] FAIL rstmid_noresp i=%0d got=%b want=0", i, BVALID);
      end
      step();
    end
    nVectors++;
    if (REG_OUT !== 512'h0) begin
      nMiss++; $display("[TB] FAIL rstmid_after got=%h want=0", REG_OUT[63:0]);
    end
    BREADY = 1'b0;
  endtask

  // Scenario sequence.
  initial begin
    nVectors = 0; nMiss = 0;
    for (int k = 0; k < 16; k++) model[k] = 32'h0;
    ARESET = 1'b1;
    AWADDR = '0; AWVALID = 1'b0; WDATA = '0; WSTRB = '0; WVALID = 1'b0;
    BREADY = 1'b0; ARADDR = '0; ARVALID = 1'b0; RREADY = 1'b0;
    test_reset();
    test_fill();
    test_order();
    test_strobe();
    test_out_of_range();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiss);
    $finish;
  end

endmodule
